// File: rtl/serdes_ctrl_pkg.sv
// rtl/serdes_ctrl_pkg.sv - shared state encoding, default timeouts and timer sizing for the lane sequencer
package serdes_ctrl_pkg;

  // Encoding is visible on state_o, so the values are fixed for ILA decoding
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOLD     = 3'd1,
    ST_WAIT_PLL = 3'd2,
    ST_WAIT_SIG = 3'd3,
    ST_WAIT_BLK = 3'd4,
    ST_LINK_UP  = 3'd5,
    ST_FAIL     = 3'd6,
    ST_HALT     = 3'd7
  } state_t;

  localparam int DEF_RST_HOLD  = 16;
  localparam int DEF_PLL_TO    = 65535;
  localparam int DEF_LOCK_TO   = 1562500;
  localparam int DEF_DEBOUNCE  = 1024;
  localparam int DEF_MAX_RETRY = 7;
  localparam int DEF_TMR_W     = 24;

  // Smallest timer width able to count up to the largest of the four intervals
  function automatic int tmr_width(input int rst_hold, input int pll_to,
                                   input int lock_to, input int debounce);
    int m;
    m = rst_hold;
    if (pll_to > m) m = pll_to;
    if (lock_to > m) m = lock_to;
    if (debounce > m) m = debounce;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/link_debounce.sv
// rtl/link_debounce.sv - consecutive-good-cycle counter with clear and done flag
module link_debounce #(
  parameter int LEN = 1024,
  parameter int CW  = $clog2(LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic good,
  output logic done
);

  logic [CW-1:0] count;

  // Count good cycles, restart on any bad cycle or clear, hold once the target is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || !good) begin
      count <= '0;
    end else if (count != CW'(LEN)) begin
      count <= count + CW'(1);
    end
  end

  assign done = (count == CW'(LEN));

endmodule

// File: rtl/serdes_link_ctrl.sv
// rtl/serdes_link_ctrl.sv - per-lane 10GBASE-R SerDes bring-up and recovery sequencer
module serdes_link_ctrl
  import serdes_ctrl_pkg::*;
#(
  parameter int RST_HOLD  = DEF_RST_HOLD,
  parameter int PLL_TO    = DEF_PLL_TO,
  parameter int LOCK_TO   = DEF_LOCK_TO,
  parameter int DEBOUNCE  = DEF_DEBOUNCE,
  parameter int MAX_RETRY = DEF_MAX_RETRY,
  parameter int TMR_W     = DEF_TMR_W
) (
  input  logic       trx_clk_156r25M,
  input  logic       rst,
  input  logic       enable,
  input  logic       trx_clk_locked,
  input  logic       pll_lock,
  input  logic       cdr_lock,
  input  logic       sfp_los,
  input  logic       block_lock,
  input  logic       hi_ber,
  output logic       serdes_tx_rstn,
  output logic       serdes_rx_rstn,
  output logic       ber_clear,
  output logic       blkerr_clear,
  output logic       link_up,
  output logic       ctrl_error,
  output logic [2:0] retry_cnt,
  output logic [2:0] state_o
);

  // Never let a too-narrow TMR_W truncate a timeout compare
  localparam int MIN_TW = tmr_width(RST_HOLD, PLL_TO, LOCK_TO, DEBOUNCE);
  localparam int TW     = (TMR_W > MIN_TW) ? TMR_W : MIN_TW;

  state_t        state;
  state_t        nxt;
  logic [TW-1:0] timer;
  logic          status_good;
  logic          deb_done;

  assign status_good = cdr_lock && block_lock && !hi_ber && !sfp_los;

  // Debounce only runs while waiting for block lock; any other state holds it cleared
  link_debounce #(
    .LEN (DEBOUNCE)
  ) u_debounce (
    .clk   (trx_clk_156r25M),
    .rst   (rst),
    .clear (state != ST_WAIT_BLK),
    .good  (status_good),
    .done  (deb_done)
  );

  // Next-state selection; losing enable or the user clock overrides everything
  always_comb begin
    nxt = state;
    if (!enable || !trx_clk_locked) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     nxt = ST_HOLD;
        ST_HOLD:     if (timer == TW'(RST_HOLD - 1)) nxt = ST_WAIT_PLL;
        ST_WAIT_PLL: begin
          if (pll_lock)                        nxt = ST_WAIT_SIG;
          else if (timer == TW'(PLL_TO - 1))   nxt = ST_FAIL;
        end
        ST_WAIT_SIG: begin
          if (!pll_lock)                       nxt = ST_FAIL;
          else if (!sfp_los)                   nxt = ST_WAIT_BLK;
        end
        ST_WAIT_BLK: begin
          if (!pll_lock || timer == TW'(LOCK_TO - 1)) nxt = ST_FAIL;
          else if (deb_done)                          nxt = ST_LINK_UP;
        end
        ST_LINK_UP: begin
          if (!block_lock || hi_ber || sfp_los || !cdr_lock || !pll_lock) nxt = ST_FAIL;
        end
        ST_FAIL:     nxt = (retry_cnt == 3'(MAX_RETRY)) ? ST_HALT : ST_HOLD;
        ST_HALT:     nxt = ST_HALT;
        default:     nxt = ST_IDLE;
      endcase
    end
  end

  // State, shared timer and every output registered from the chosen next state
  always_ff @(posedge trx_clk_156r25M or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      timer          <= '0;
      serdes_tx_rstn <= 1'b0;
      serdes_rx_rstn <= 1'b0;
      ber_clear      <= 1'b0;
      blkerr_clear   <= 1'b0;
      link_up        <= 1'b0;
      ctrl_error     <= 1'b0;
      retry_cnt      <= 3'd0;
    end else begin
      state <= nxt;

      if (nxt != state)       timer <= '0;
      else if (timer != '1)   timer <= timer + TW'(1);

      serdes_tx_rstn <= nxt inside {ST_WAIT_PLL, ST_WAIT_SIG, ST_WAIT_BLK, ST_LINK_UP};
      serdes_rx_rstn <= nxt inside {ST_WAIT_BLK, ST_LINK_UP};
      link_up        <= (nxt == ST_LINK_UP);
      ber_clear      <= (nxt == ST_LINK_UP) && (state != ST_LINK_UP);
      blkerr_clear   <= (nxt == ST_LINK_UP) && (state != ST_LINK_UP);
      ctrl_error     <= (nxt == ST_HALT);

      if (nxt == ST_IDLE) begin
        retry_cnt <= 3'd0;
      end else if (nxt == ST_LINK_UP && state != ST_LINK_UP) begin
        retry_cnt <= 3'd0;
      end else if (nxt == ST_FAIL && state != ST_FAIL && retry_cnt != 3'd7) begin
        retry_cnt <= retry_cnt + 3'd1;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_serdes_link_ctrl.sv
// tb/tb_serdes_link_ctrl.sv - directed self-checking bench for serdes_link_ctrl
module tb_serdes_link_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       trx_clk_locked = 1'b1;
  logic       pll_lock = 1'b1;
  logic       cdr_lock = 1'b1;
  logic       sfp_los = 1'b0;
  logic       block_lock = 1'b1;
  logic       hi_ber = 1'b0;
  logic       serdes_tx_rstn;
  logic       serdes_rx_rstn;
  logic       ber_clear;
  logic       blkerr_clear;
  logic       link_up;
  logic       ctrl_error;
  logic [2:0] retry_cnt;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_state;
  int exp_retry;

  always #5 clk = ~clk;

  serdes_link_ctrl #(
    .RST_HOLD  (4),
    .PLL_TO    (20),
    .LOCK_TO   (200),
    .DEBOUNCE  (8),
    .MAX_RETRY (7),
    .TMR_W     (24)
  ) dut (
    .trx_clk_156r25M (clk),
    .rst             (rst),
    .enable          (enable),
    .trx_clk_locked  (trx_clk_locked),
    .pll_lock        (pll_lock),
    .cdr_lock        (cdr_lock),
    .sfp_los         (sfp_los),
    .block_lock      (block_lock),
    .hi_ber          (hi_ber),
    .serdes_tx_rstn  (serdes_tx_rstn),
    .serdes_rx_rstn  (serdes_rx_rstn),
    .ber_clear       (ber_clear),
    .blkerr_clear    (blkerr_clear),
    .link_up         (link_up),
    .ctrl_error      (ctrl_error),
    .retry_cnt       (retry_cnt),
    .state_o         (state_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, "_tx"}, serdes_tx_rstn, 0);
    chk({tag, "_rx"}, serdes_rx_rstn, 0);
    chk({tag, "_link"}, link_up, 0);
    chk({tag, "_ber"}, ber_clear, 0);
    chk({tag, "_blk"}, blkerr_clear, 0);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_low("rst");
    chk("rst_err", ctrl_error, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_state", state_o, 0);
    rst = 1'b0;
    tick;
    chk("idle_state", state_o, 0);

    // nominal bring-up
    enable = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 17; c++) begin
      tick;
      exp_state = (cyc < 5) ? 1 : (cyc == 5) ? 2 : (cyc == 6) ? 3 : (cyc < 16) ? 4 : 5;
      chk("nom_state", state_o, exp_state);
      chk("nom_tx", serdes_tx_rstn, cyc >= 5);
      chk("nom_rx", serdes_rx_rstn, cyc >= 7);
      chk("nom_link", link_up, cyc >= 16);
      chk("nom_ber", ber_clear, cyc == 16);
      chk("nom_blk", blkerr_clear, cyc == 16);
      chk("nom_retry", retry_cnt, 0);
    end

    // link loss through hi_ber
    hi_ber = 1'b1;
    tick;
    chk("loss_link", link_up, 0);
    chk("loss_rx", serdes_rx_rstn, 0);
    chk("loss_tx", serdes_tx_rstn, 0);
    chk("loss_retry", retry_cnt, 1);
    chk("loss_state", state_o, 6);
    hi_ber = 1'b0;
    tick;
    chk("loss_hold", state_o, 1);
    for (int c = 0; c < 14; c++) begin
      tick;
      chk("loss_nolink", link_up, 0);
    end
    tick;
    chk("relink_link", link_up, 1);
    chk("relink_ber", ber_clear, 1);
    chk("relink_retry", retry_cnt, 0);
    chk("relink_state", state_o, 5);
    tick;
    chk("relink_pulse_end", ber_clear, 0);

    // abort via enable in WAIT_BLK
    enable = 1'b0;
    tick;
    chk("dis_state", state_o, 0);
    chk_all_low("dis");
    enable = 1'b1;
    repeat (10) tick;
    chk("abort_en_pre", state_o, 4);
    enable = 1'b0;
    tick;
    chk("abort_en_state", state_o, 0);
    chk_all_low("abort_en");

    // abort via trx_clk_locked in WAIT_BLK
    enable = 1'b1;
    repeat (7) tick;
    chk("abort_lk_pre", state_o, 4);
    trx_clk_locked = 1'b0;
    tick;
    chk("abort_lk_state", state_o, 0);
    chk_all_low("abort_lk");
    trx_clk_locked = 1'b1;

    // block_lock glitch at debounce count 6 delays link_up by 7 cycles
    cyc = 0;
    while (cyc < 13) tick;
    chk("glitch_pre", state_o, 4);
    block_lock = 1'b0;
    tick;
    chk("glitch_state", state_o, 4);
    block_lock = 1'b1;
    while (cyc < 22) begin
      tick;
      chk("glitch_nolink", link_up, 0);
      chk("glitch_blk", state_o, 4);
    end
    tick;
    chk("glitch_link", link_up, 1);
    chk("glitch_ber", ber_clear, 1);
    chk("glitch_retry", retry_cnt, 0);

    // fibre absent parks in WAIT_SIG
    enable = 1'b0;
    tick;
    sfp_los = 1'b1;
    enable = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      tick;
      if (cyc >= 6) begin
        chk("los_state", state_o, 3);
        chk("los_rx", serdes_rx_rstn, 0);
      end
    end
    chk("los_tx", serdes_tx_rstn, 1);
    chk("los_retry", retry_cnt, 0);
    sfp_los = 1'b0;
    tick;
    chk("los_go_state", state_o, 4);
    chk("los_go_rx", serdes_rx_rstn, 1);
    repeat (8) tick;
    chk("los_nolink", link_up, 0);
    tick;
    chk("los_link", link_up, 1);

    // asynchronous reset mid LINK_UP
    #3;
    rst = 1'b1;
    #1;
    chk_all_low("arst");
    chk("arst_state", state_o, 0);
    chk("arst_retry", retry_cnt, 0);
    chk("arst_err", ctrl_error, 0);

    // PLL timeout retries until HALT
    pll_lock = 1'b0;
    #2;
    rst = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      tick;
      exp_retry = (cyc / 25 > 7) ? 7 : cyc / 25;
      chk("pll_retry", retry_cnt, exp_retry);
      chk("pll_err", ctrl_error, cyc >= 176);
      chk("pll_rx", serdes_rx_rstn, 0);
      if (cyc == 5)   chk("pll_tx_rel", serdes_tx_rstn, 1);
      if (cyc == 24)  chk("pll_wait", state_o, 2);
      if (cyc == 25) begin
        chk("pll_fail", state_o, 6);
        chk("pll_fail_tx", serdes_tx_rstn, 0);
      end
      if (cyc == 26)  chk("pll_rehold", state_o, 1);
      if (cyc == 175) chk("pll_last_fail", state_o, 6);
      if (cyc >= 176) begin
        chk("pll_halt", state_o, 7);
        chk("pll_halt_tx", serdes_tx_rstn, 0);
      end
    end
    enable = 1'b0;
    tick;
    chk("halt_exit_state", state_o, 0);
    chk("halt_exit_err", ctrl_error, 0);
    chk("halt_exit_retry", retry_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serdes_link_ctrl.md
Name: serdes_link_ctrl

Overview:
Per-lane bring-up and recovery sequencer for one 10GBASE-R SerDes channel. It drives the lane's tx/rx reset inputs, watches PLL/CDR/block-lock/BER status and SFP loss-of-signal, and pulses the BER and errored-block counter clears on link-up. It instantiates once per SFP+ cage, between the board clock/reset logic and the SerDes/XGMII wrapper. It also presents a clean link_up flag to the UDP/MAC layer.

Parameters:
RST_HOLD, 16, cycles both resets are held low before tx release and after any failure
PLL_TO, 65535, max cycles to wait for pll_lock after tx release
LOCK_TO, 1562500, max cycles (10 ms at 156.25 MHz) to reach a stable block lock after rx release
DEBOUNCE, 1024, consecutive good-status cycles required before declaring link up
MAX_RETRY, 7, failed attempts before the controller halts
TMR_W, 24, width of the shared timer; must hold max(RST_HOLD, PLL_TO, LOCK_TO, DEBOUNCE)

Ports:
trx_clk_156r25M  in  1  sole clock, 156.25 MHz XGMII/SerDes user clock
rst  in  1  asynchronous, active-high reset
enable  in  1  1: run bring-up; 0: force IDLE
trx_clk_locked  in  1  user-clock PLL locked
pll_lock  in  1  SerDes PLL lock (debug vector bit 0)
cdr_lock  in  1  SerDes CDR lock (debug vector bit 1)
sfp_los  in  1  SFP loss of signal, 1 = no light
block_lock  in  1  64b66b block lock
hi_ber  in  1  PCS high BER
serdes_tx_rstn  out  1  to SerDes tx_rstn
serdes_rx_rstn  out  1  to SerDes rx_rstn
ber_clear  out  1  one-cycle pulse to clear_ber_count
blkerr_clear  out  1  one-cycle pulse to clear_errored_block_count
link_up  out  1  lane usable
ctrl_error  out  1  retries exhausted, halted
retry_cnt  out  3  failed attempts since last link-up, saturating
state_o  out  3  current state encoding, for debug/ILA

Behaviour:
- Reset values: tx_rstn = 0, rx_rstn = 0, pulses = 0, link_up = 0, ctrl_error = 0, retry_cnt = 0, state = IDLE, timer = 0.
- All outputs are registered.
- Timer: one shared up-counter. It clears on every state change and saturates at all-ones.
- States and encoding:
  - IDLE = 0: both resets low, retry_cnt cleared. Go to HOLD when enable && trx_clk_locked.
  - HOLD = 1: both resets low. After RST_HOLD cycles go to WAIT_PLL; tx_rstn rises on the same edge.
  - WAIT_PLL = 2: pll_lock = 1 goes to WAIT_SIG. If the timer reaches PLL_TO first, go to FAIL.
  - WAIT_SIG = 3: no timeout. sfp_los = 0 goes to WAIT_BLK; rx_rstn rises on the same edge. pll_lock = 0 goes to FAIL.
  - WAIT_BLK = 4: a good cycle is cdr_lock && block_lock && !hi_ber && !sfp_los.
    - The debounce counter advances on good cycles and resets to 0 on any bad cycle.
    - After DEBOUNCE consecutive good cycles, go to LINK_UP.
    - LOCK_TO expiry (measured from state entry) or pll_lock = 0 goes to FAIL.
  - LINK_UP = 5: on entry, link_up = 1, ber_clear = blkerr_clear = 1 for exactly one cycle, and retry_cnt = 0. Any of block_lock = 0, hi_ber = 1, sfp_los = 1, cdr_lock = 0 or pll_lock = 0 goes to FAIL; link_up drops on that same edge.
  - FAIL = 6: single cycle. Both resets go low and retry_cnt increments.
    - If the new retry_cnt equals MAX_RETRY, go to HALT.
    - Otherwise go to HOLD.
  - HALT = 7: resets low, ctrl_error = 1. Exits only via enable = 0, which goes to IDLE and clears ctrl_error and retry_cnt.
- Global overrides, priority order, from any state on the next edge:
  1. rst (asynchronous).
  2. enable = 0 or trx_clk_locked = 0: go to IDLE, resets low, link_up = 0.
  3. The state logic above.
- Status inputs are treated as already synchronous to trx_clk_156r25M; no synchronizers are inside the block.
- sfp_los may be undriven in the lab; the integrator ties it to 0 in that case.
- Latency: with all status good and constant, link_up asserts RST_HOLD + DEBOUNCE + 4 cycles after enable rises.
- Enable deasserting mid-sequence (e.g. in WAIT_BLK) aborts cleanly. No clear pulses are emitted.

Decomposition:
- Package serdes_ctrl_pkg holds:
  - the state enum (3-bit encoding as listed above),
  - the default timeout constants,
  - a function that computes TMR_W from the timeouts.
- One optional sub-module, link_debounce: a consecutive-good counter with a clear input and a done output. Everything else stays flat.
- Top level instantiates two serdes_link_ctrl blocks, one per lane.

Test Plan:
- Nominal bring-up. Params RST_HOLD = 4, DEBOUNCE = 8. Enable = 1 at cycle 0 with all status good.
  - tx_rstn rises at cycle 5, rx_rstn rises at cycle 7.
  - link_up rises at cycle 16 together with one-cycle ber_clear and blkerr_clear.
  - retry_cnt = 0.
- PLL timeout. Params PLL_TO = 20, pll_lock held at 0.
  - FAIL is entered 20 cycles after tx release, retry_cnt becomes 1, and HOLD is re-entered.
  - After 7 attempts ctrl_error = 1, state = 7, and both resets are held low.
- Block-lock glitch during debounce. Drop block_lock for 1 cycle at debounce count 6.
  - The counter restarts, and link_up is delayed by 7 cycles versus the nominal case.
  - No FAIL occurs as long as LOCK_TO has not expired.
- Link loss. From LINK_UP, assert hi_ber = 1.
  - Next edge: link_up = 0, rx_rstn = 0, tx_rstn = 0, retry_cnt = 1.
  - With status restored, link_up returns and retry_cnt is back to 0.
- Fibre absent. Hold sfp_los = 1.
  - The block parks in WAIT_SIG indefinitely with rx_rstn = 0 and no retries.
  - Deasserting sfp_los proceeds to WAIT_BLK on the next edge.
- Aborts.
  - Dropping enable or trx_clk_locked in WAIT_BLK gives IDLE next cycle, both resets low, and no clear pulses.
  - Asserting rst mid-LINK_UP clears every output immediately (asynchronously).
